// File: rtl/cdu_inject_pkg.sv
// cdu_inject_pkg: register map, axis request states and the direction helper
// shared by the CDU angle injector.
package cdu_inject_pkg;

    localparam int unsigned NUM_AXES = 5;

    // Monitor register map of the injector (lives beside the CDU readback defines).
    localparam logic [15:0] CDU_INJ_REG_TGTX   = 16'h0000;
    localparam logic [15:0] CDU_INJ_REG_TGTY   = 16'h0001;
    localparam logic [15:0] CDU_INJ_REG_TGTZ   = 16'h0002;
    localparam logic [15:0] CDU_INJ_REG_TGTT   = 16'h0003;
    localparam logic [15:0] CDU_INJ_REG_TGTS   = 16'h0004;
    localparam logic [15:0] CDU_INJ_REG_ENABLE = 16'h0005;
    localparam logic [15:0] CDU_INJ_REG_STATUS = 16'h0006;
    localparam logic [15:0] CDU_INJ_REG_SHDX   = 16'h0008;
    localparam logic [15:0] CDU_INJ_REG_SHDY   = 16'h0009;
    localparam logic [15:0] CDU_INJ_REG_SHDZ   = 16'h000A;
    localparam logic [15:0] CDU_INJ_REG_SHDT   = 16'h000B;
    localparam logic [15:0] CDU_INJ_REG_SHDS   = 16'h000C;

    // Per-axis handshake state: idle, or holding an up / down request.
    typedef enum logic [1:0] {
        AX_IDLE = 2'd0,
        AX_UP   = 2'd1,
        AX_DOWN = 2'd2
    } axis_state_e;

    // Shortest-path direction on the 15-bit ring; a half-turn difference goes down.
    function automatic logic wants_down(input logic [14:0] tgt, input logic [14:0] shd);
        logic [14:0] diff;
        diff = tgt - shd;
        return diff[14];
    endfunction

endpackage

// File: rtl/cdu_inject_axis.sv
// cdu_inject_axis: one CDU axis - target/shadow/enable, direction compare,
// request/ack handshake. Optional ack timeout with sticky error when the
// macro CDU_INJECT_TIMEOUT_EN is defined.
module cdu_inject_axis
    import cdu_inject_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        tick,
    input  logic        tgt_we,
    input  logic        shd_we,
    input  logic        en_we,
    input  logic        en_wdata,
`ifdef CDU_INJECT_TIMEOUT_EN
    input  logic        err_clr,
`endif
    input  logic [14:0] wdata,
    input  logic        ack,
    output logic [14:0] target,
    output logic [14:0] shadow,
    output logic        enable,
    output logic        pending,
    output logic        error,
    output logic        up,
    output logic        down
);

    axis_state_e state_reg, state_next;
    logic [14:0] target_reg;
    logic [14:0] shadow_reg, shadow_next;
    logic        enable_reg;
    logic        timeout_hit;

`ifdef CDU_INJECT_TIMEOUT_EN
    logic [15:0] wait_cnt_reg;
    logic        error_reg;

    // The last waiting cycle without an ack abandons the request.
    assign timeout_hit = (state_reg != AX_IDLE) && !ack
                         && (wait_cnt_reg == 16'(TIMEOUT - 1));
    assign error       = error_reg;

    // Wait counter runs only while a request is outstanding; error is sticky until cleared.
    always_ff @(posedge clk) begin
        if (srst) begin
            wait_cnt_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            if (state_reg == AX_IDLE) begin
                wait_cnt_reg <= '0;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + 16'd1;
            end
            if (timeout_hit) begin
                error_reg <= 1'b1;
            end else if (err_clr) begin
                error_reg <= 1'b0;
            end
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    // Request FSM: launch on a tick when behind target, release on ack (or timeout).
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            AX_IDLE: begin
                if (tick && enable_reg && !error && (target_reg != shadow_reg)) begin
                    state_next = wants_down(target_reg, shadow_reg) ? AX_DOWN : AX_UP;
                end
            end
            AX_UP, AX_DOWN: begin
                if (ack || timeout_hit) begin
                    state_next = AX_IDLE;
                end
            end
            default: state_next = AX_IDLE;
        endcase
    end

    // Shadow follows serviced requests; a host write in the same cycle wins over the ack.
    always_comb begin
        shadow_next = shadow_reg;
        if (shd_we) begin
            shadow_next = wdata;
        end else if (ack && (state_reg == AX_UP)) begin
            shadow_next = shadow_reg + 15'd1;
        end else if (ack && (state_reg == AX_DOWN)) begin
            shadow_next = shadow_reg - 15'd1;
        end
    end

    // Axis registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= AX_IDLE;
            target_reg <= '0;
            shadow_reg <= '0;
            enable_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shadow_reg <= shadow_next;
            if (tgt_we) begin
                target_reg <= wdata;
            end
            if (en_we) begin
                enable_reg <= en_wdata;
            end
        end
    end

    assign target  = target_reg;
    assign shadow  = shadow_reg;
    assign enable  = enable_reg;
    assign pending = (state_reg != AX_IDLE);
    assign up      = (state_reg == AX_UP);
    assign down    = (state_reg == AX_DOWN);

endmodule

// File: rtl/cdu_inject.sv
// cdu_inject: monitor-side CDU angle injector. Pacing divider, register
// decode and read mux around five cdu_inject_axis instances. Build option
// CDU_INJECT_TIMEOUT_EN adds per-axis ack timeout and sticky error bits.
module cdu_inject
    import cdu_inject_pkg::*;
#(
    parameter int unsigned RATE_DIV = 7812,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        read_en,
    input  logic        write_en,
    output logic        write_done,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic [4:0]  cdu_up,
    output logic [4:0]  cdu_down,
    input  logic [4:0]  cdu_ack
);

    logic [15:0] pace_cnt_reg;
    logic        tick;
    logic        write_done_reg;
    logic [15:0] data_out_reg;
    logic [15:0] rd_mux;
    logic [14:0] target_w [NUM_AXES];
    logic [14:0] shadow_w [NUM_AXES];
    logic [4:0]  enable_w;
    logic [4:0]  pending_w;
    logic [4:0]  error_w;
    logic        unused_data_msb;

    assign unused_data_msb = data_in[15];
    assign tick = (pace_cnt_reg == '0);

    // Shared pacing down-counter: one tick every RATE_DIV cycles.
    always_ff @(posedge clk) begin
        if (srst || tick) begin
            pace_cnt_reg <= 16'(RATE_DIV - 1);
        end else begin
            pace_cnt_reg <= pace_cnt_reg - 16'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            cdu_inject_axis #(
                .TIMEOUT (TIMEOUT)
            ) u_axis (
                .clk      (clk),
                .srst     (srst),
                .tick     (tick),
                .tgt_we   (write_en && (addr == CDU_INJ_REG_TGTX + 16'(gi))),
                .shd_we   (write_en && (addr == CDU_INJ_REG_SHDX + 16'(gi))),
                .en_we    (write_en && (addr == CDU_INJ_REG_ENABLE)),
                .en_wdata (data_in[gi]),
`ifdef CDU_INJECT_TIMEOUT_EN
                .err_clr  (write_en && (addr == CDU_INJ_REG_STATUS) && data_in[8+gi]),
`endif
                .wdata    (data_in[14:0]),
                .ack      (cdu_ack[gi]),
                .target   (target_w[gi]),
                .shadow   (shadow_w[gi]),
                .enable   (enable_w[gi]),
                .pending  (pending_w[gi]),
                .error    (error_w[gi]),
                .up       (cdu_up[gi]),
                .down     (cdu_down[gi])
            );
        end
    endgenerate

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_AXES; i++) begin
            if (addr == CDU_INJ_REG_TGTX + 16'(i)) begin
                rd_mux = {1'b0, target_w[i]};
            end
            if (addr == CDU_INJ_REG_SHDX + 16'(i)) begin
                rd_mux = {1'b0, shadow_w[i]};
            end
        end
        if (addr == CDU_INJ_REG_ENABLE) begin
            rd_mux = {11'd0, enable_w};
        end
        if (addr == CDU_INJ_REG_STATUS) begin
            rd_mux = {3'd0, error_w, 3'd0, pending_w};
        end
    end

    // Bus responses: write acknowledge and read data, each live for one cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            write_done_reg <= 1'b0;
            data_out_reg   <= '0;
        end else begin
            write_done_reg <= write_en;
            data_out_reg   <= read_en ? rd_mux : 16'd0;
        end
    end

    assign write_done = write_done_reg;
    assign data_out   = data_out_reg;

endmodule
